// File: rtl/ysyx_23060136_exu_bru_pkg.sv
// Shared types and constants for the EX2 branch resolution unit.
package ysyx_23060136_exu_bru_pkg;

  localparam int          BRU_BITS_W = 64;
  localparam logic [63:0] BRU_PC_RST = 64'h8000_0000;

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } bru_state_e;

endpackage

// File: rtl/ysyx_23060136_exu_bru_cmp.sv
// Branch condition evaluation: OR of the selected compares.
// With no compare selected, the transfer is unconditional.
module ysyx_23060136_exu_bru_cmp #(
  parameter int BITS_W = 64
) (
  input  logic [BITS_W-1:0] rs1,
  input  logic [BITS_W-1:0] rs2,
  input  logic              cmp_eq,
  input  logic              cmp_neq,
  input  logic              cmp_ge,
  input  logic              cmp_lt,
  input  logic              cmp_unsigned,
  output logic              cond
);

  logic equal;
  logic less;
  logic any_cmp;

  assign equal   = (rs1 == rs2);
  assign less    = cmp_unsigned ? (rs1 < rs2) : ($signed(rs1) < $signed(rs2));
  assign any_cmp = cmp_eq | cmp_neq | cmp_ge | cmp_lt;

  assign cond = ~any_cmp
              | (cmp_eq  &  equal)
              | (cmp_neq & ~equal)
              | (cmp_ge  & ~less)
              | (cmp_lt  &  less);

endmodule

// File: rtl/ysyx_23060136_exu_bru.sv
// EX2 branch resolution: decides taken/target, flushes the front end and
// hands the redirect PC to the IFU over a valid/ready handshake.
module ysyx_23060136_exu_bru
  import ysyx_23060136_exu_bru_pkg::*;
#(
  parameter int                BITS_W = BRU_BITS_W,
  parameter logic [BITS_W-1:0] PC_RST = BITS_W'(BRU_PC_RST)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              FORWARD_stallEX2,
  input  logic              EXU2_commit,
  input  logic [BITS_W-1:0] EXU2_pc,
  input  logic [BITS_W-1:0] EXU2_imm,
  input  logic [BITS_W-1:0] EXU2_HAZARD_rs1_data,
  input  logic [BITS_W-1:0] EXU2_HAZARD_rs2_data,
  input  logic [BITS_W-1:0] EXU2_HAZARD_csr_rs_data,
  input  logic              EXU2_jump,
  input  logic              EXU2_pc_plus_imm,
  input  logic              EXU2_rs1_plus_imm,
  input  logic              EXU2_csr_plus_imm,
  input  logic              EXU2_cmp_eq,
  input  logic              EXU2_cmp_neq,
  input  logic              EXU2_cmp_ge,
  input  logic              EXU2_cmp_lt,
  input  logic              EXU2_cmp_unsigned,
  output logic              BRANCH_flushIF,
  output logic              BRANCH_flushID,
  output logic              BRANCH_flushEX1,
  output logic              redirect_valid,
  input  logic              redirect_ready,
  output logic [BITS_W-1:0] redirect_pc,
  output logic [63:0]       perf_branch_cnt,
  output logic [63:0]       perf_taken_cnt
);

  bru_state_e        state;
  logic              resolve;
  logic              cond;
  logic              taken;
  logic              flush;
  logic [BITS_W-1:0] rs1_sum;
  logic [BITS_W-1:0] target;

  assign resolve = EXU2_jump & EXU2_commit & ~FORWARD_stallEX2 & ~rst;
  assign taken   = resolve & cond;

  ysyx_23060136_exu_bru_cmp #(
    .BITS_W(BITS_W)
  ) u_cmp (
    .rs1         (EXU2_HAZARD_rs1_data),
    .rs2         (EXU2_HAZARD_rs2_data),
    .cmp_eq      (EXU2_cmp_eq),
    .cmp_neq     (EXU2_cmp_neq),
    .cmp_ge      (EXU2_cmp_ge),
    .cmp_lt      (EXU2_cmp_lt),
    .cmp_unsigned(EXU2_cmp_unsigned),
    .cond        (cond)
  );

  assign rs1_sum = EXU2_HAZARD_rs1_data + EXU2_imm;

  always_comb begin
    target = EXU2_pc + EXU2_imm;
    if (EXU2_pc_plus_imm)       target = EXU2_pc + EXU2_imm;
    else if (EXU2_rs1_plus_imm) target = {rs1_sum[BITS_W-1:1], 1'b0};
    else if (EXU2_csr_plus_imm) target = EXU2_HAZARD_csr_rs_data + EXU2_imm;
  end

  // Flush is held for the whole pending window so nothing fetched on the
  // stale path can enter the pipe before the IFU takes the redirect.
  assign flush           = ~rst & (taken | (state == PEND));
  assign BRANCH_flushIF  = flush;
  assign BRANCH_flushID  = flush;
  assign BRANCH_flushEX1 = flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      redirect_valid  <= 1'b0;
      redirect_pc     <= PC_RST;
      perf_branch_cnt <= '0;
      perf_taken_cnt  <= '0;
    end else begin
      perf_branch_cnt <= perf_branch_cnt + 64'(resolve);
      perf_taken_cnt  <= perf_taken_cnt + 64'(taken);
      case (state)
        IDLE: begin
          if (taken) begin
            state          <= PEND;
            redirect_valid <= 1'b1;
            redirect_pc    <= target;
          end
        end
        PEND: begin
          // A younger taken transfer replaces the redirect even if the IFU
          // was accepting the old one this cycle.
          if (taken) begin
            redirect_pc <= target;
          end else if (redirect_ready) begin
            state          <= IDLE;
            redirect_valid <= 1'b0;
          end
        end
        default: begin
          state          <= IDLE;
          redirect_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_23060136_exu_bru.sv
// Scoreboard bench for the EX2 branch resolution unit: expected outputs are
// queued as each cycle's stimulus is driven and compared mid-cycle.
module tb_ysyx_23060136_exu_bru;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, commit, jump;
  logic [63:0] pc, imm, rs1, rs2, csr;
  logic        sel_pc, sel_rs1, sel_csr;
  logic        eq, neq, ge, lt, uns;
  logic        ready;
  logic        flush_if, flush_id, flush_ex1;
  logic        redirect_valid;
  logic [63:0] redirect_pc, branch_cnt, taken_cnt;

  typedef struct {
    logic        flush;
    logic        valid;
    logic [63:0] pc;
    logic [63:0] bcnt;
    logic [63:0] tcnt;
  } exp_t;

  exp_t sb[$];

  // reference state
  logic        m_pend, m_valid;
  logic [63:0] m_pc, m_bcnt, m_tcnt;

  int n_cmp = 0;
  int n_bad = 0;
  int n_cyc = 0;

  always #5 clk = ~clk;

  ysyx_23060136_exu_bru dut (
    .clk                    (clk),
    .rst                    (rst),
    .FORWARD_stallEX2       (stall),
    .EXU2_commit            (commit),
    .EXU2_pc                (pc),
    .EXU2_imm               (imm),
    .EXU2_HAZARD_rs1_data   (rs1),
    .EXU2_HAZARD_rs2_data   (rs2),
    .EXU2_HAZARD_csr_rs_data(csr),
    .EXU2_jump              (jump),
    .EXU2_pc_plus_imm       (sel_pc),
    .EXU2_rs1_plus_imm      (sel_rs1),
    .EXU2_csr_plus_imm      (sel_csr),
    .EXU2_cmp_eq            (eq),
    .EXU2_cmp_neq           (neq),
    .EXU2_cmp_ge            (ge),
    .EXU2_cmp_lt            (lt),
    .EXU2_cmp_unsigned      (uns),
    .BRANCH_flushIF         (flush_if),
    .BRANCH_flushID         (flush_id),
    .BRANCH_flushEX1        (flush_ex1),
    .redirect_valid         (redirect_valid),
    .redirect_ready         (ready),
    .redirect_pc            (redirect_pc),
    .perf_branch_cnt        (branch_cnt),
    .perf_taken_cnt         (taken_cnt)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, got, exp, n_cyc);
    end
  endtask

  function automatic logic ref_cond();
    logic less;
    if (!(eq | neq | ge | lt)) return 1'b1;
    less = uns ? (rs1 < rs2) : ($signed(rs1) < $signed(rs2));
    return (eq && rs1 == rs2) || (neq && rs1 != rs2) || (ge && !less) || (lt && less);
  endfunction

  function automatic logic [63:0] ref_target();
    logic [63:0] t;
    if (sel_pc)       t = pc + imm;
    else if (sel_rs1) t = (rs1 + imm) & ~64'd1;
    else if (sel_csr) t = csr + imm;
    else              t = pc + imm;
    return t;
  endfunction

  task automatic clear_inputs();
    stall = 0; commit = 0; jump = 0;
    pc = 0; imm = 0; rs1 = 0; rs2 = 0; csr = 0;
    sel_pc = 0; sel_rs1 = 0; sel_csr = 0;
    eq = 0; neq = 0; ge = 0; lt = 0; uns = 0;
  endtask

  // One clock of stimulus: called just after a rising edge with inputs set.
  task automatic cycle();
    exp_t        e;
    logic        res, tk;
    logic [63:0] tgt;
    res = jump & commit & ~stall & ~rst;
    tk  = res & ref_cond();
    tgt = ref_target();
    e.flush = ~rst & (tk | m_pend);
    e.valid = m_valid;
    e.pc    = m_pc;
    e.bcnt  = m_bcnt;
    e.tcnt  = m_tcnt;
    sb.push_back(e);
    @(negedge clk);
    e = sb.pop_front();
    check("flushIF",  {63'd0, flush_if},       {63'd0, e.flush});
    check("flushID",  {63'd0, flush_id},       {63'd0, e.flush});
    check("flushEX1", {63'd0, flush_ex1},      {63'd0, e.flush});
    check("valid",    {63'd0, redirect_valid}, {63'd0, e.valid});
    check("pc",       redirect_pc,             e.pc);
    check("bcnt",     branch_cnt,              e.bcnt);
    check("tcnt",     taken_cnt,               e.tcnt);
    $display("cyc %0d rst=%0b stall=%0b jump=%0b taken=%0b rdy=%0b flush=%0b valid=%0b rpc=%h",
             n_cyc, rst, stall, jump, tk, ready, flush_if, redirect_valid, redirect_pc);
    if (rst) begin
      m_pend = 0; m_valid = 0; m_pc = 64'h8000_0000; m_bcnt = 0; m_tcnt = 0;
    end else begin
      m_bcnt = m_bcnt + 64'(res);
      m_tcnt = m_tcnt + 64'(tk);
      if (tk) begin
        m_pend = 1; m_valid = 1; m_pc = tgt;
      end else if (m_pend && ready) begin
        m_pend = 0; m_valid = 0;
      end
    end
    @(posedge clk);
    #1;
    n_cyc++;
  endtask

  task automatic branch(input logic [63:0] p, input logic [63:0] i,
                        input logic [63:0] a, input logic [63:0] b);
    clear_inputs();
    jump = 1; commit = 1; pc = p; imm = i; rs1 = a; rs2 = b;
  endtask

  initial begin
    clear_inputs();
    rst = 1; ready = 1;
    m_pend = 0; m_valid = 0; m_pc = 64'h8000_0000; m_bcnt = 0; m_tcnt = 0;
    @(posedge clk); #1;
    cycle(); cycle();
    rst = 0;
    cycle();

    // beq taken
    branch(64'h8000_0010, 64'h20, 64'd5, 64'd5); eq = 1; sel_pc = 1;
    cycle();
    clear_inputs();
    check("beq_valid", {63'd0, redirect_valid}, 64'd1);
    check("beq_pc", redirect_pc, 64'h8000_0030);
    check("beq_tcnt", taken_cnt, 64'd1);
    cycle(); cycle();

    // blt signed taken, then unsigned not taken
    branch(64'h8000_0100, 64'h40, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1); lt = 1;
    cycle();
    clear_inputs(); cycle();
    branch(64'h8000_0100, 64'h40, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1); lt = 1; uns = 1;
    cycle();
    clear_inputs();
    check("blt_bcnt", branch_cnt, 64'd3);
    check("blt_tcnt", taken_cnt, 64'd2);
    check("bltu_valid", {63'd0, redirect_valid}, 64'd0);
    cycle();

    // jalr clears bit 0
    branch(64'h8000_0200, 64'd4, 64'h8000_0101, 64'd0); sel_rs1 = 1;
    cycle();
    clear_inputs();
    check("jalr_pc", redirect_pc, 64'h8000_0104);
    cycle();

    // IFU back-pressure for three cycles
    branch(64'h8000_0300, 64'h10, 64'd7, 64'd8); neq = 1; ready = 0;
    cycle();
    clear_inputs();
    cycle(); cycle(); cycle();
    check("hold_pc", redirect_pc, 64'h8000_0310);
    ready = 1;
    cycle();
    cycle();

    // stalled resolution resolves exactly once
    branch(64'h8000_0400, 64'h8, 64'd3, 64'd3); ge = 1; stall = 1;
    cycle(); cycle();
    stall = 0;
    cycle();
    clear_inputs();
    check("stall_bcnt", branch_cnt, 64'd6);
    cycle(); cycle();

    // reset while pending discards the redirect
    branch(64'h8000_0500, 64'h8, 64'd0, 64'd0); csr = 64'h8000_1000; sel_csr = 1; ready = 0;
    cycle();
    clear_inputs();
    cycle();
    rst = 1;
    cycle();
    rst = 0; ready = 1;
    check("rst_valid", {63'd0, redirect_valid}, 64'd0);
    check("rst_pc", redirect_pc, 64'h8000_0000);
    check("rst_bcnt", branch_cnt, 64'd0);
    cycle();

    // random traffic
    for (int k = 0; k < 300; k++) begin
      int kind;
      clear_inputs();
      jump   = ($urandom_range(0, 1) == 1);
      commit = ($urandom_range(0, 4) != 0);
      stall  = ($urandom_range(0, 3) == 0);
      ready  = ($urandom_range(0, 2) != 0);
      rst    = ($urandom_range(0, 99) == 0);
      pc  = {32'd0, $urandom()};
      imm = {$urandom(), $urandom()};
      csr = {32'd0, $urandom()};
      rs1 = {$urandom(), $urandom()};
      rs2 = ($urandom_range(0, 3) == 0) ? rs1 : {$urandom(), $urandom()};
      uns = ($urandom_range(0, 1) == 1);
      sel_pc  = ($urandom_range(0, 2) == 0);
      sel_rs1 = ($urandom_range(0, 1) == 1);
      sel_csr = ($urandom_range(0, 1) == 1);
      kind = $urandom_range(0, 4);
      eq  = (kind == 1);
      neq = (kind == 2);
      ge  = (kind == 3);
      lt  = (kind == 4);
      cycle();
    end

    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
